prbs_gen_mc: RTL and testbench
==============================

Name: prbs_gen_mc

Overview:
Parametrised successor of the team's 8-bit preamble + PRBS-15 source. It emits a user pattern word repeated n times, then a pseudo-random stream from a run-time-selectable LFSR (PRBS7/15/23/31). Each output beat advances the LFSR by OUT_W bits. Downstream backpressure uses a valid/ready handshake, and a programmable PRBS length ends the burst. The block sits in the link-test datapath, feeding the serializer/checker.

Parameters:
OUT_W, 8, output beat width in bits (1..32)
PAT_BYTES, 4, pattern word width in bytes; pattern width = 8*PAT_BYTES, and PAT_BYTES*8 must be a multiple of OUT_W
LFSR_W, 31, LFSR register width; must be at least 31 to support every mode
CNT_W, 16, width of the repeat and length counters

Ports:
CLK  in  1  clock; all logic is on the rising edge
RST  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; launches a burst when the block is IDLE, ignored otherwise
stop  in  1  abort; returns the block to IDLE on the next edge
mode  in  2  0=PRBS7 (taps 7,6), 1=PRBS15 (15,14), 2=PRBS23 (23,18), 3=PRBS31 (31,28); sampled at start
seed  in  LFSR_W  LFSR seed; the low k bits are used, k = polynomial order; sampled at start
pattern  in  8*PAT_BYTES  preamble word; sampled at start
n  in  CNT_W  number of pattern repetitions; sampled at start
prbs_len  in  CNT_W  number of PRBS beats; 0 = run until stop; sampled at start
out_data  out  OUT_W  output beat
out_valid  out  1  out_data is valid
out_ready  in  1  downstream accepts the beat
busy  out  1  high while not IDLE
pattern_done  out  1  high while in PRBS or DONE
done  out  1  one-cycle pulse in the cycle DONE is entered

Behaviour:
- Reset (RST=1 at an edge): state=IDLE; out_data=0, out_valid=0, busy=0, pattern_done=0, done=0; LFSR and counters cleared. Reset wins over every other input.
- State machine: IDLE -> PATTERN -> PRBS -> DONE -> IDLE.
- IDLE: out_valid=0.
  - start=1 latches mode, seed, pattern, n and prbs_len; next state is PATTERN, or PRBS if n=0.
  - A latched seed whose low k bits are zero is replaced by all-ones in those k bits (no lock-up).
- Beat rule: a beat transfers when out_valid && out_ready.
  - While out_valid=1 && out_ready=0, out_data and the state are held stable.
  - out_valid is registered; the first beat is valid one cycle after the start edge.
- PATTERN:
  - Slices the pattern MSB-first into PAT_BYTES*8/OUT_W beats.
  - After the last slice of repetition n, the next state is PRBS with no gap cycle; the first PRBS beat follows directly.
- PRBS, per beat:
  - OUT_W single-bit steps are computed combinationally.
  - Each step: fb = s[t1-1] ^ s[t2-1]; s <= {s[k-2:0], fb}.
  - out_data holds the fb bits in generation order; the first generated bit goes to the MSB.
  - The LFSR advances only on a transferred beat.
  - After beat number prbs_len transfers (prbs_len != 0), the next state is DONE.
- DONE: out_valid=0 and done pulses for one cycle; the next cycle returns to IDLE with pattern_done=0.
- stop=1 (not in reset): next state is IDLE and out_valid=0 with no done pulse. stop takes priority over start and over a beat transfer in the same cycle.
- Counters wrap-free: the repeat counter compares against n-1, the length counter against prbs_len-1.
- Mode/seed changes while busy have no effect until the next start.

Decomposition:
- Package prbs_pkg holds:
  - typedef enum of the states (IDLE, PATTERN, PRBS, DONE)
  - typedef enum prbs_mode_e (PRBS7, PRBS15, PRBS23, PRBS31)
  - tap/order constant function get_taps(mode) returning k, t1 and t2
- Sub-module prbs_lfsr_step (combinational, parameter OUT_W) takes the current state and mode and returns the next state plus the OUT_W output bits. The top level holds the FSM, counters and handshake.

Test Plan:
1. Reset, then start with pattern=32'hDEADBEEF, n=2, OUT_W=8, out_ready=1 -> beats DE AD BE EF DE AD BE EF; pattern_done rises on beat 9.
2. n=0, mode=PRBS7, seed=7'h7F, prbs_len=3 -> first beat 8'h02 immediately; exactly 3 beats; done pulses once; busy drops.
3. PRBS15, seed=0 -> seed forced to 15'h7FFF; the stream matches the golden model for 2^15-1 bits, and the period repeats exactly.
4. Random out_ready stalls during PATTERN and PRBS -> out_data is stable while stalled; the stream is identical to the out_ready=1 run.
5. stop asserted mid-PRBS together with out_ready=1 -> next cycle IDLE, out_valid=0, no done; a new start replays from the seed.
6. RST asserted mid-pattern -> all outputs 0 on the next edge; start in the reset cycle is ignored.

Source files
------------

// File: rtl/prbs_gen_mc_pkg.sv
// prbs_pkg: shared types and polynomial tables for the pattern + PRBS source.
//   state_e     : burst state machine states
//   prbs_mode_e : run-time polynomial selection (PRBS7/15/23/31)
//   taps_t      : polynomial order k and the two feedback taps t1, t2
//   lfsr_order  : order k of a polynomial
//   get_taps    : order and taps of a polynomial
package prbs_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PATTERN = 2'd1,
      PRBS    = 2'd2,
      DONE    = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      PRBS7  = 2'd0,
      PRBS15 = 2'd1,
      PRBS23 = 2'd2,
      PRBS31 = 2'd3
   } prbs_mode_e;

   typedef struct packed {
      logic [5:0] k;
      logic [5:0] t1;
      logic [5:0] t2;
   } taps_t;

   function automatic logic [5:0] lfsr_order(prbs_mode_e m);
      logic [5:0] k;
      case (m)
         PRBS7:   k = 6'd7;
         PRBS15:  k = 6'd15;
         PRBS23:  k = 6'd23;
         default: k = 6'd31;
      endcase
      return k;
   endfunction

   function automatic taps_t get_taps(prbs_mode_e m);
      taps_t t;
      t.k = lfsr_order(m);
      case (m)
         PRBS7:   begin t.t1 = 6'd7;  t.t2 = 6'd6;  end
         PRBS15:  begin t.t1 = 6'd15; t.t2 = 6'd14; end
         PRBS23:  begin t.t1 = 6'd23; t.t2 = 6'd18; end
         default: begin t.t1 = 6'd31; t.t2 = 6'd28; end
      endcase
      return t;
   endfunction

endpackage

// File: rtl/prbs_gen_mc_if.sv
// prbs_gen_mc_if: valid/ready output stream of the pattern + PRBS source.
//   out_data  : output beat (OUT_W bits)
//   out_valid : out_data holds a beat
//   out_ready : sink accepts the beat
// master = source side, slave = sink side.
interface prbs_gen_mc_if #(
   parameter int OUT_W = 8
) ();
   logic [OUT_W-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/prbs_gen_mc_lfsr_step.sv
// prbs_lfsr_step: purely combinational OUT_W-bit advance of the Fibonacci LFSR.
//   state_i : current LFSR state (only the low k bits are meaningful)
//   mode_i  : selected polynomial
//   next_o  : LFSR state after OUT_W single-bit steps
//   bits_o  : the OUT_W feedback bits, first generated bit in the MSB
module prbs_lfsr_step
   import prbs_pkg::*;
#(
   parameter int OUT_W  = 8,
   parameter int LFSR_W = 31
) (
   input  logic [LFSR_W-1:0] state_i,
   input  prbs_mode_e        mode_i,
   output logic [LFSR_W-1:0] next_o,
   output logic [OUT_W-1:0]  bits_o
);

   localparam logic [LFSR_W-1:0] ONE = {{(LFSR_W-1){1'b0}}, 1'b1};

   taps_t             taps;
   logic [LFSR_W-1:0] mask;
   logic [LFSR_W-1:0] t1_m;
   logic [LFSR_W-1:0] t2_m;
   logic [LFSR_W-1:0] s;
   logic              fb;

   always_comb begin
      taps   = get_taps(mode_i);
      mask   = {LFSR_W{1'b1}} >> (LFSR_W - int'(taps.k));
      t1_m   = ONE << (taps.t1 - 6'd1);
      t2_m   = ONE << (taps.t2 - 6'd1);
      s      = state_i & mask;
      fb     = 1'b0;
      bits_o = '0;
      // NOTE: blocking assignments here are deliberate: each loop pass must see
      // the state produced by the previous pass, unrolling into a chain of gates.
      for (int i = 0; i < OUT_W; i++) begin
         fb                 = (|(s & t1_m)) ^ (|(s & t2_m));
         bits_o[OUT_W-1-i]  = fb;
         s                  = ((s << 1) | {{(LFSR_W-1){1'b0}}, fb}) & mask;
      end
      next_o = s;
   end

endmodule

// File: rtl/prbs_gen_mc.sv
// prbs_gen_mc: link-test source. Emits a pattern word n times (MSB-first slices),
// then a PRBS7/15/23/31 stream of OUT_W-bit beats, over a valid/ready stream.
//   CLK, RST     : clock, synchronous active-high reset
//   start, stop  : launch a burst from IDLE / abort back to IDLE
//   mode, seed, pattern, n, prbs_len : burst configuration, captured at start
//   out_if       : output stream (master side)
//   busy         : not IDLE; pattern_done: in PRBS or DONE; done: DONE entered
module prbs_gen_mc
   import prbs_pkg::*;
#(
   parameter int OUT_W     = 8,
   parameter int PAT_BYTES = 4,
   parameter int LFSR_W    = 31,
   parameter int CNT_W     = 16
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   start,
   input  logic                   stop,
   input  logic [1:0]             mode,
   input  logic [LFSR_W-1:0]      seed,
   input  logic [8*PAT_BYTES-1:0] pattern,
   input  logic [CNT_W-1:0]       n,
   input  logic [CNT_W-1:0]       prbs_len,
   prbs_gen_mc_if.master          out_if,
   output logic                   busy,
   output logic                   pattern_done,
   output logic                   done
);

   localparam int PW     = 8 * PAT_BYTES;
   localparam int SLICES = PW / OUT_W;
   localparam int SW     = (SLICES > 1) ? $clog2(SLICES) : 1;
   localparam logic [SW-1:0]    SLICE_LAST = SW'(SLICES - 1);
   localparam logic [SW-1:0]    SLICE_ONE  = 1;
   localparam logic [CNT_W-1:0] CNT_ONE    = 1;

   state_e            state_q, state_d;
   prbs_mode_e        mode_q, mode_d;
   logic [LFSR_W-1:0] lfsr_q, lfsr_d;
   logic [PW-1:0]     pattern_q, pattern_d;
   logic [CNT_W-1:0]  n_q, n_d;
   logic [CNT_W-1:0]  len_q, len_d;
   logic [CNT_W-1:0]  rep_q, rep_d;
   logic [CNT_W-1:0]  beat_q, beat_d;
   logic [SW-1:0]     slice_q, slice_d;
   logic [OUT_W-1:0]  data_q, data_d;
   logic              valid_q, valid_d;

   logic [LFSR_W-1:0] seed_mask;
   logic [LFSR_W-1:0] seed_fix;
   logic [LFSR_W-1:0] step_state;
   prbs_mode_e        step_mode;
   logic [LFSR_W-1:0] step_next;
   logic [OUT_W-1:0]  step_bits;
   logic              xfer;

   function automatic logic [OUT_W-1:0] slice_of(logic [PW-1:0] w, int idx);
      logic [PW-1:0] t;
      t = w << (idx * OUT_W);
      return t[PW-1 -: OUT_W];
   endfunction

   // An all-zero seed would lock the LFSR up; substitute all-ones in the k bits.
   assign seed_mask = {LFSR_W{1'b1}} >> (LFSR_W - int'(lfsr_order(prbs_mode_e'(mode))));
   assign seed_fix  = ((seed & seed_mask) == '0) ? seed_mask : (seed & seed_mask);

   // In IDLE the stepper runs on the incoming seed so that an n=0 burst has its
   // first PRBS beat ready right after the start edge. lfsr_q always holds the
   // state after the beat currently presented in data_q.
   assign step_state = (state_q == IDLE) ? seed_fix : lfsr_q;
   assign step_mode  = (state_q == IDLE) ? prbs_mode_e'(mode) : mode_q;

   prbs_lfsr_step #(
      .OUT_W  (OUT_W),
      .LFSR_W (LFSR_W)
   ) u_step (
      .state_i (step_state),
      .mode_i  (step_mode),
      .next_o  (step_next),
      .bits_o  (step_bits)
   );

   assign xfer = valid_q && out_if.out_ready;

   always_comb begin
      // NOTE: every _d defaults to its _q so no path leaves a variable
      // unassigned, which would otherwise infer a latch.
      state_d   = state_q;
      mode_d    = mode_q;
      lfsr_d    = lfsr_q;
      pattern_d = pattern_q;
      n_d       = n_q;
      len_d     = len_q;
      rep_d     = rep_q;
      beat_d    = beat_q;
      slice_d   = slice_q;
      data_d    = data_q;
      valid_d   = valid_q;

      case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            if (start) begin
               mode_d    = prbs_mode_e'(mode);
               pattern_d = pattern;
               n_d       = n;
               len_d     = prbs_len;
               rep_d     = '0;
               beat_d    = '0;
               slice_d   = '0;
               valid_d   = 1'b1;
               if (n == '0) begin
                  state_d = PRBS;
                  data_d  = step_bits;
                  lfsr_d  = step_next;
               end else begin
                  state_d = PATTERN;
                  data_d  = pattern[PW-1 -: OUT_W];
                  lfsr_d  = seed_fix;
               end
            end
         end
         PATTERN: begin
            if (xfer) begin
               if (slice_q == SLICE_LAST) begin
                  slice_d = '0;
                  if (rep_q == n_q - CNT_ONE) begin
                     // Last slice of the last repetition: first PRBS beat follows
                     // on the very next cycle.
                     state_d = PRBS;
                     data_d  = step_bits;
                     lfsr_d  = step_next;
                  end else begin
                     rep_d  = rep_q + CNT_ONE;
                     data_d = slice_of(pattern_q, 0);
                  end
               end else begin
                  slice_d = slice_q + SLICE_ONE;
                  data_d  = slice_of(pattern_q, int'(slice_q) + 1);
               end
            end
         end
         PRBS: begin
            if (xfer) begin
               if ((len_q != '0) && (beat_q == len_q - CNT_ONE)) begin
                  state_d = DONE;
                  valid_d = 1'b0;
               end else begin
                  beat_d = beat_q + CNT_ONE;
                  data_d = step_bits;
                  lfsr_d = step_next;
               end
            end
         end
         DONE: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (stop) begin
         state_d = IDLE;
         valid_d = 1'b0;
      end
   end

   // NOTE: sequential state is updated only with non-blocking assignments so
   // every register samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         mode_q    <= PRBS7;
         lfsr_q    <= '0;
         pattern_q <= '0;
         n_q       <= '0;
         len_q     <= '0;
         rep_q     <= '0;
         beat_q    <= '0;
         slice_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         lfsr_q    <= lfsr_d;
         pattern_q <= pattern_d;
         n_q       <= n_d;
         len_q     <= len_d;
         rep_q     <= rep_d;
         beat_q    <= beat_d;
         slice_q   <= slice_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
      end
   end

   assign out_if.out_data  = data_q;
   assign out_if.out_valid = valid_q;
   assign busy             = (state_q != IDLE);
   assign pattern_done     = (state_q == PRBS) || (state_q == DONE);
   assign done             = (state_q == DONE);

endmodule

// File: tb/tb_prbs_gen_mc.sv
// Scoreboard bench for prbs_gen_mc. Expected beats come from a bit-level
// recurrence model a[i] = a[i-t1] ^ a[i-t2] seeded from the seed history.
module tb_prbs_gen_mc;

   localparam int OUT_W     = 8;
   localparam int PAT_BYTES = 4;
   localparam int LFSR_W    = 31;
   localparam int CNT_W     = 16;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [30:0] seed = '0;
   logic [31:0] pattern = '0;
   logic [15:0] n = '0;
   logic [15:0] prbs_len = '0;
   logic        busy;
   logic        pattern_done;
   logic        done;

   prbs_gen_mc_if #(.OUT_W(OUT_W)) bus ();

   prbs_gen_mc #(
      .OUT_W     (OUT_W),
      .PAT_BYTES (PAT_BYTES),
      .LFSR_W    (LFSR_W),
      .CNT_W     (CNT_W)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .start        (start),
      .stop         (stop),
      .mode         (mode),
      .seed         (seed),
      .pattern      (pattern),
      .n            (n),
      .prbs_len     (prbs_len),
      .out_if       (bus),
      .busy         (busy),
      .pattern_done (pattern_done),
      .done         (done)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0] data;
      logic       pd;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] rx_log[$];
   int         n_checks = 0;
   int         n_pass   = 0;
   int         done_cnt = 0;
   bit         stall_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   // ---------------- reference model ----------------
   task automatic model_push(input int m, input logic [30:0] sd, input logic [31:0] pat,
                             input int reps, input int prbs_beats);
      int          k, t1, t2;
      bit          hist[$];
      logic [30:0] msk, eff, tmp;
      logic [7:0]  b;
      bit          nb;
      exp_t        e;
      case (m)
         0:       begin k = 7;  t1 = 7;  t2 = 6;  end
         1:       begin k = 15; t1 = 15; t2 = 14; end
         2:       begin k = 23; t1 = 23; t2 = 18; end
         default: begin k = 31; t1 = 31; t2 = 28; end
      endcase
      for (int r = 0; r < reps; r++)
         for (int j = 0; j < 4; j++) begin
            e.data = 8'(pat >> (8 * (3 - j)));
            e.pd   = 1'b0;
            exp_q.push_back(e);
         end
      msk = (31'(1) << k) - 31'(1);
      eff = sd & msk;
      if (eff == '0) eff = msk;
      // History oldest-first: seed bit k-1 is a[-k], seed bit 0 is a[-1].
      for (int j = k - 1; j >= 0; j--) begin
         tmp = eff >> j;
         hist.push_back(tmp[0]);
      end
      for (int i = 0; i < prbs_beats; i++) begin
         b = '0;
         for (int j = 0; j < 8; j++) begin
            nb = hist[hist.size() - t1] ^ hist[hist.size() - t2];
            hist.push_back(nb);
            void'(hist.pop_front());
            b = {b[6:0], nb};
         end
         e.data = b;
         e.pd   = 1'b1;
         exp_q.push_back(e);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   bit         was_stalled = 1'b0;
   logic [7:0] held = '0;
   exp_t       mon_e;

   always @(negedge CLK) begin
      if (done) done_cnt++;
      if (was_stalled) begin
         check("stall_valid_held", 64'(bus.out_valid), 64'(1));
         check("stall_data_held", 64'(bus.out_data), 64'(held));
      end
      was_stalled = bus.out_valid && !bus.out_ready && !stop && !RST;
      held        = bus.out_data;
      if (bus.out_valid && bus.out_ready && !stop && !RST) begin
         rx_log.push_back(bus.out_data);
         check("beat_expected", 64'(exp_q.size() != 0), 64'(1));
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("beat_data", 64'(bus.out_data), 64'(mon_e.data));
            check("beat_pattern_done", 64'(pattern_done), 64'(mon_e.pd));
         end
      end
   end

   // ---------------- backpressure driver ----------------
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge CLK);
         #1;
         bus.out_ready = stall_en ? ($urandom_range(0, 99) >= 40) : 1'b1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, required end of test");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic launch(input int m, input logic [30:0] sd, input logic [31:0] pat,
                         input int nn, input int len);
      mode     = 2'(m);
      seed     = sd;
      pattern  = pat;
      n        = 16'(nn);
      prbs_len = 16'(len);
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int c = 0;
      while (busy && c < budget) begin
         tick();
         c++;
      end
      check({name, "_idle"}, 64'(busy), 64'(0));
      check({name, "_drained"}, 64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      int          d0;
      int          c;
      int          mism;
      int          m;
      int          nn;
      int          len;
      logic [30:0] sd;
      logic [31:0] pat;
      logic [7:0]  log_a[$];
      bit          bits[$];
      logic [7:0]  tmp8;

      // Reset state
      RST = 1'b1;
      repeat (3) tick();
      check("rst_out_data", 64'(bus.out_data), 64'(0));
      check("rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_pattern_done", 64'(pattern_done), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      RST = 1'b0;
      tick();

      // 1: pattern DEADBEEF twice, then a short PRBS7 tail
      d0 = done_cnt;
      model_push(0, 31'h1234, 32'hDEADBEEF, 2, 4);
      launch(0, 31'h1234, 32'hDEADBEEF, 2, 4);
      wait_idle("t1", 200);
      tick();
      check("t1_done_pulses", 64'(done_cnt - d0), 64'(1));

      // 2: n=0, PRBS7 all-ones seed, three beats
      d0 = done_cnt;
      rx_log.delete();
      model_push(0, 31'h7F, 32'h0, 0, 3);
      launch(0, 31'h7F, 32'h0, 0, 3);
      check("t2_first_valid", 64'(bus.out_valid), 64'(1));
      check("t2_first_data", 64'(bus.out_data), 64'(8'h02));
      wait_idle("t2", 100);
      tick();
      check("t2_beat_count", 64'(rx_log.size()), 64'(3));
      check("t2_done_pulses", 64'(done_cnt - d0), 64'(1));

      // 3: PRBS15 zero seed, two full periods
      rx_log.delete();
      model_push(1, 31'h0, 32'h0, 0, 8192);
      launch(1, 31'h0, 32'h0, 0, 8192);
      wait_idle("t3", 9000);
      bits.delete();
      foreach (rx_log[i])
         for (int j = 7; j >= 0; j--) begin
            tmp8 = rx_log[i] >> j;
            bits.push_back(tmp8[0]);
         end
      mism = 0;
      for (int i = 0; i + 32767 < bits.size(); i++)
         if (bits[i] != bits[i + 32767]) mism++;
      check("t3_period_mismatches", 64'(mism), 64'(0));
      check("t3_bits_seen", 64'(bits.size()), 64'(65536));

      // 4: random stalls vs. free-running replay
      for (int it = 0; it < 3; it++) begin
         m   = int'($urandom_range(0, 3));
         sd  = 31'($urandom());
         pat = $urandom();
         nn  = int'($urandom_range(1, 3));
         len = int'($urandom_range(20, 40));
         rx_log.delete();
         stall_en = 1'b1;
         model_push(m, sd, pat, nn, len);
         launch(m, sd, pat, nn, len);
         wait_idle("t4_stall", 600);
         stall_en = 1'b0;
         tick();
         log_a = rx_log;
         rx_log.delete();
         model_push(m, sd, pat, nn, len);
         launch(m, sd, pat, nn, len);
         wait_idle("t4_free", 200);
         check("t4_len_equal", 64'(log_a.size()), 64'(rx_log.size()));
         mism = 0;
         foreach (log_a[i])
            if (i >= rx_log.size() || log_a[i] !== rx_log[i]) mism++;
         check("t4_stream_equal", 64'(mism), 64'(0));
      end

      // 5: stop mid-PRBS with out_ready high, then replay from the seed
      d0  = done_cnt;
      sd  = 31'($urandom());
      pat = $urandom();
      rx_log.delete();
      model_push(2, sd, pat, 1, 40);
      launch(2, sd, pat, 1, 0);
      c = 0;
      while (rx_log.size() < 14 && c < 100) begin
         tick();
         c++;
      end
      check("t5_reached_prbs", 64'(rx_log.size() >= 14), 64'(1));
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("t5_valid_low", 64'(bus.out_valid), 64'(0));
      check("t5_busy_low", 64'(busy), 64'(0));
      exp_q.delete();
      tick();
      tick();
      check("t5_no_done", 64'(done_cnt - d0), 64'(0));
      d0 = done_cnt;
      model_push(2, sd, pat, 1, 6);
      launch(2, sd, pat, 1, 6);
      wait_idle("t5_replay", 100);
      tick();
      check("t5_replay_done", 64'(done_cnt - d0), 64'(1));

      // 6: reset mid-pattern, with start in the reset cycle
      pat = $urandom();
      model_push(3, 31'h5, pat, 4, 0);
      launch(3, 31'h5, pat, 4, 0);
      repeat (5) tick();
      RST   = 1'b1;
      start = 1'b1;
      tick();
      check("t6_out_data", 64'(bus.out_data), 64'(0));
      check("t6_out_valid", 64'(bus.out_valid), 64'(0));
      check("t6_busy", 64'(busy), 64'(0));
      check("t6_pattern_done", 64'(pattern_done), 64'(0));
      check("t6_done", 64'(done), 64'(0));
      RST   = 1'b0;
      start = 1'b0;
      exp_q.delete();
      tick();
      tick();
      check("t6_start_ignored", 64'(busy), 64'(0));
      check("t6_valid_idle", 64'(bus.out_valid), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
